// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared loader state type and frame constants
package loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN_LO,
    LEN_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream input and instruction-memory write port of the loader
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_word_pack.sv
// rtl/imem_word_pack.sv - packs little-endian bytes into 32-bit words, strobes on the last byte
module imem_word_pack
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_done_o
);

  logic [31:0] shift_q;
  logic [31:0] shift_d;
  logic [1:0]  cnt_q;

  // Shifting right lands the first byte of a word in bits 7:0 after four shifts.
  assign shift_d     = {byte_i, shift_q[31:8]};
  assign word_o      = shift_d;
  assign word_done_o = byte_valid_i && (cnt_q == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (byte_valid_i) begin
      shift_q <= shift_d;
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - framed byte-stream loader writing the instruction memory and gating cpu_hold
module imem_loader
  import loader_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic load_en,
  output logic cpu_hold,
  output logic done,
  output logic error,
  imem_loader_if.master bus
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int LEN_W  = LEN_BYTES * 8;

  loader_state_t     state_q;
  logic [LEN_W-1:0]  len_q;
  logic [ADDR_W:0]   word_cnt_q;
  logic [7:0]        csum_q;
  logic              rx_ready_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              done_q;
  logic              error_q;
  logic              hold_q;

  logic              xfer;
  logic              data_xfer;
  logic              start;
  logic [LEN_W-1:0]  len_full;
  logic              last_word;
  logic [31:0]       word;
  logic              word_done;

  assign xfer      = bus.rx_valid && rx_ready_q;
  assign data_xfer = xfer && (state_q == DATA);
  assign start     = load_en && (state_q == IDLE || state_q == DONE || state_q == ERR);
  assign len_full  = {bus.rx_data, len_q[7:0]};
  assign last_word = (32'(word_cnt_q) + 32'd1) == 32'(len_q);

  imem_word_pack u_pack (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (start),
    .byte_valid_i (data_xfer),
    .byte_i       (bus.rx_data),
    .word_o       (word),
    .word_done_o  (word_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      word_cnt_q <= '0;
      csum_q     <= '0;
      rx_ready_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      hold_q     <= 1'b1;
    end else begin
      we_q <= 1'b0;
      if (start) begin
        state_q    <= LEN_LO;
        len_q      <= '0;
        word_cnt_q <= '0;
        csum_q     <= '0;
        rx_ready_q <= 1'b1;
        done_q     <= 1'b0;
        error_q    <= 1'b0;
        hold_q     <= 1'b1;
      end else if (xfer) begin
        case (state_q)
          LEN_LO: begin
            len_q[7:0] <= bus.rx_data;
            state_q    <= LEN_HI;
          end
          LEN_HI: begin
            len_q[15:8] <= bus.rx_data;
            if (32'(len_full) > 32'(DEPTH)) begin
              state_q    <= ERR;
              error_q    <= 1'b1;
              rx_ready_q <= 1'b0;
            end else if (len_full == '0) begin
              state_q <= CSUM;
            end else begin
              state_q <= DATA;
            end
          end
          DATA: begin
            csum_q <= csum_q ^ bus.rx_data;
            if (word_done) begin
              we_q       <= 1'b1;
              addr_q     <= word_cnt_q[ADDR_W-1:0];
              wdata_q    <= word;
              word_cnt_q <= word_cnt_q + 1'b1;
              if (last_word) state_q <= CSUM;
            end
          end
          CSUM: begin
            rx_ready_q <= 1'b0;
            if (bus.rx_data == csum_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
              hold_q  <= 1'b0;
            end else begin
              state_q <= ERR;
              error_q <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.rx_ready   = rx_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign done           = done_q;
  assign error          = error_q;
  assign cpu_hold       = hold_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized frame stimulus against a frame-level reference model
module tb_imem_loader;

  typedef logic [7:0]  byte_q_t[$];
  typedef logic [31:0] word_q_t[$];
  typedef struct {
    int          due;
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_en = 1'b0;
  logic cpu_hold, done, error;

  imem_loader_if #(.ADDR_W(8)) bus ();

  imem_loader #(.ADDR_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .load_en  (load_en),
    .cpu_hold (cpu_hold),
    .done     (done),
    .error    (error),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ncyc   = 0;
  bit chk_en = 1'b0;
  wr_t exp_q[$];
  logic [39:0] log_q[$];
  logic exp_done = 1'b0, exp_err = 1'b0, exp_hold = 1'b1, exp_rdy = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the frame-level model
  always @(negedge clk) begin
    ncyc++;
    if (chk_en) begin
      chk("done", 64'(done), 64'(exp_done));
      chk("error", 64'(error), 64'(exp_err));
      chk("cpu_hold", 64'(cpu_hold), 64'(exp_hold));
      chk("rx_ready", 64'(bus.rx_ready), 64'(exp_rdy));
      if (bus.imem_we) begin
        log_q.push_back({bus.imem_addr, bus.imem_wdata});
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_we: got addr %0h data %0h expected no write", bus.imem_addr, bus.imem_wdata);
        end else begin
          chk("we_cycle", 64'(ncyc), 64'(exp_q[0].due));
          chk("we_addr", 64'(bus.imem_addr), 64'(exp_q[0].addr));
          chk("we_data", 64'(bus.imem_wdata), 64'(exp_q[0].data));
          void'(exp_q.pop_front());
        end
      end else if (exp_q.size() > 0 && exp_q[0].due <= ncyc) begin
        checks++;
        errors++;
        $display("FAIL missing_we: got no write expected addr %0h data %0h", exp_q[0].addr, exp_q[0].data);
        void'(exp_q.pop_front());
      end
    end
  end

  function automatic byte_q_t make_frame(input word_q_t w, input bit bad);
    byte_q_t f;
    logic [7:0] x = 8'h00;
    f.push_back(8'(w.size()));
    f.push_back(8'(w.size() >> 8));
    foreach (w[i]) begin
      for (int b = 0; b < 4; b++) begin
        f.push_back(w[i][8*b +: 8]);
        x ^= w[i][8*b +: 8];
      end
    end
    f.push_back(bad ? (x ^ 8'h01) : x);
    return f;
  endfunction

  task automatic pulse_load();
    load_en = 1'b1;
    @(posedge clk);
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_hold = 1'b1;
    exp_rdy  = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, output bit ok);
    int n = 0;
    bus.rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.rx_ready) begin
      errors++;
      $display("FAIL byte_timeout: got rx_ready 0 expected 1 within 100 cycles");
      bus.rx_valid = 1'b0;
      ok = 1'b0;
    end else begin
      @(posedge clk);
      ok = 1'b1;
    end
  endtask

  // Model updates follow directly from the frame layout: length, 4N data bytes, XOR checksum.
  task automatic send_frame(input byte_q_t fr, input int maxgap, input int nsend, input int poke);
    int n, last, cnt;
    bit ovf, good, ok;
    logic [7:0] x = 8'h00;
    n    = int'({fr[1], fr[0]});
    ovf  = n > 256;
    last = ovf ? 1 : 2 + 4 * n;
    if (!ovf) for (int i = 2; i < 2 + 4 * n; i++) x ^= fr[i];
    good = !ovf && (fr[last] == x);
    cnt  = (nsend >= 0) ? nsend : last + 1;
    for (int i = 0; i < cnt; i++) begin
      if (i == poke) load_en = 1'b1;
      send_byte(fr[i], $urandom_range(0, maxgap), ok);
      if (!ok) break;
      if (i >= 2 && i < 2 + 4 * n && !ovf && ((i - 2) % 4) == 3)
        exp_q.push_back('{ncyc + 1, 8'((i - 2) / 4), {fr[i], fr[i-1], fr[i-2], fr[i-3]}});
      if (i == last) begin
        exp_rdy = 1'b0;
        if (good) begin
          exp_done = 1'b1;
          exp_hold = 1'b0;
        end else begin
          exp_err = 1'b1;
        end
      end
      @(negedge clk);
      load_en = 1'b0;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_frame1(input string tag);
    chk({tag, "_nwr"}, 64'(log_q.size()), 64'd2);
    if (log_q.size() >= 2) begin
      chk({tag, "_wr0"}, 64'(log_q[0]), 64'h00_00500093);
      chk({tag, "_wr1"}, 64'(log_q[1]), 64'h01_00A00113);
    end
  endtask

  byte_q_t frame1;
  byte_q_t fr;
  word_q_t w;

  initial begin
    frame1 = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    chk("rst_we", 64'(bus.imem_we), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("rst_wdata", 64'(bus.imem_wdata), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    chk("rst_hold", 64'(cpu_hold), 64'd1);
    rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);

    // Normal back-to-back load
    pulse_load();
    log_q.delete();
    send_frame(frame1, 0, -1, -1);
    repeat (2) @(negedge clk);
    check_frame1("normal");
    chk("normal_done", 64'(done), 64'd1);
    chk("normal_hold", 64'(cpu_hold), 64'd0);

    // Stalled stream, then bytes offered while DONE must be ignored
    pulse_load();
    log_q.delete();
    send_frame(frame1, 3, -1, -1);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h55;
    repeat (4) @(negedge clk);
    bus.rx_valid = 1'b0;
    check_frame1("stall");
    chk("stall_done", 64'(done), 64'd1);

    // Empty frame
    pulse_load();
    log_q.delete();
    send_frame('{8'h00, 8'h00, 8'h00}, 1, -1, -1);
    repeat (2) @(negedge clk);
    chk("empty_nwr", 64'(log_q.size()), 64'd0);
    chk("empty_done", 64'(done), 64'd1);
    chk("empty_hold", 64'(cpu_hold), 64'd0);

    // Bad checksum, then recovery
    pulse_load();
    log_q.delete();
    fr = frame1;
    fr[10] = 8'h70;
    send_frame(fr, 0, -1, -1);
    repeat (2) @(negedge clk);
    check_frame1("badcs");
    chk("badcs_error", 64'(error), 64'd1);
    chk("badcs_done", 64'(done), 64'd0);
    chk("badcs_hold", 64'(cpu_hold), 64'd1);
    pulse_load();
    send_frame(frame1, 1, -1, -1);
    repeat (2) @(negedge clk);
    chk("recover_done", 64'(done), 64'd1);

    // Length overflow (257 words)
    pulse_load();
    log_q.delete();
    send_frame('{8'h01, 8'h01}, 0, -1, -1);
    repeat (3) @(negedge clk);
    chk("ovf_error", 64'(error), 64'd1);
    chk("ovf_ready", 64'(bus.rx_ready), 64'd0);
    chk("ovf_nwr", 64'(log_q.size()), 64'd0);

    // Exactly full memory (256 words)
    pulse_load();
    log_q.delete();
    w.delete();
    for (int i = 0; i < 256; i++) w.push_back($urandom);
    send_frame(make_frame(w, 1'b0), 0, -1, -1);
    repeat (2) @(negedge clk);
    chk("full_nwr", 64'(log_q.size()), 64'd256);
    if (log_q.size() == 256) chk("full_last", 64'(log_q[255]), {24'd0, 8'hFF, w[255]});
    chk("full_done", 64'(done), 64'd1);

    // Reset after the 6th data byte
    pulse_load();
    log_q.delete();
    send_frame(frame1, 0, 8, -1);
    #2;
    rst = 1'b0;
    exp_done = 1'b0;
    exp_err  = 1'b0;
    exp_hold = 1'b1;
    exp_rdy  = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(bus.rx_ready), 64'd0);
    chk("mid_rst_we", 64'(bus.imem_we), 64'd0);
    chk("mid_rst_addr", 64'(bus.imem_addr), 64'd0);
    chk("mid_rst_wdata", 64'(bus.imem_wdata), 64'd0);
    chk("mid_rst_hold", 64'(cpu_hold), 64'd1);
    chk("mid_rst_nwr", 64'(log_q.size()), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pulse_load();
    log_q.delete();
    send_frame(frame1, 0, -1, -1);
    repeat (2) @(negedge clk);
    check_frame1("after_rst");
    chk("after_rst_done", 64'(done), 64'd1);

    // Randomized frames, with stray load_en pulses mid-frame and occasional overflow
    for (int k = 0; k < 25; k++) begin
      pulse_load();
      if ($urandom_range(0, 7) == 0) begin
        fr.delete();
        fr.push_back(8'($urandom_range(1, 255)));
        fr.push_back(8'($urandom_range(1, 3)));
      end else begin
        w.delete();
        for (int i = 0; i < $urandom_range(0, 6); i++) w.push_back($urandom);
        fr = make_frame(w, $urandom_range(0, 3) == 0);
      end
      send_frame(fr, $urandom_range(0, 2), -1, ($urandom_range(0, 1) == 1) ? 4 : -1);
      repeat ($urandom_range(1, 4)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no completion expected finish within 1ms");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-stream program loader that fills the instruction memory read by the fetch stage, i.e. the writer side of the instruction-memory interface. It accepts a framed byte stream (length, little-endian instruction words, XOR checksum), assembles 32-bit words, and issues one write per word into the instruction memory write port. While loading, it holds the pipeline in reset through `cpu_hold`. It releases the pipeline only after a frame with a valid checksum.

## Interface
- `ADDR_W`, default 8: instruction-memory word-address width; depth is 2**ADDR_W words.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `load_en`  in  1  single-cycle pulse that starts a load; honoured only in IDLE, DONE, ERR.
- `rx_valid`  in  1  byte-stream valid.
- `rx_data`  in  8  byte-stream data.
- `rx_ready`  out  1  loader accepts a byte; a transfer occurs when `rx_valid && rx_ready`.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address of the write.
- `imem_wdata`  out  32  instruction word.
- `cpu_hold`  out  1  high holds the pipeline in reset (drives the pipeline reset input).
- `done`  out  1  level; frame loaded and checksum matched.
- `error`  out  1  level; length overflow or checksum mismatch.

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit word count N, little-endian), then 4*N data bytes (each word little-endian, byte 0 = bits 7:0), then CSUM.
- CSUM is the XOR of all 4*N data bytes. The length bytes are excluded. The initial value is 0x00.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR.
- IDLE: `load_en` moves to LEN_LO. It also clears the word counter, byte counter and checksum.
- LEN_LO: store the low length byte on transfer, then go to LEN_HI.
- LEN_HI: store the high length byte on transfer.
  - If N > 2**ADDR_W, go to ERR.
  - If N == 0, go to CSUM.
  - Otherwise go to DATA.
- DATA: each transfer shifts the byte into the 32-bit assembly register and XORs it into the checksum.
  - On the 4th byte of a word, a write is issued: `imem_addr` = word index (starting at 0), `imem_wdata` = the assembled word.
  - After word N-1 is written, go to CSUM.
- CSUM: on transfer, compare the received byte with the running XOR. A match goes to DONE; a mismatch goes to ERR.
- DONE: `done`=1, `cpu_hold`=0.
- ERR: `error`=1, `cpu_hold`=1. Words already written are not rolled back.
- `load_en` in DONE or ERR restarts the load exactly as from IDLE, and clears `done` and `error`. `load_en` in LEN_LO..CSUM is ignored.
- `rx_ready`=1 only in LEN_LO, LEN_HI, DATA, CSUM. Bytes offered in other states are not consumed.
- Word index width is ADDR_W+1 so that N = 2**ADDR_W is reachable. `imem_addr` takes the low ADDR_W bits.

## Timing
- Reset values: `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `done`=0, `error`=0, `cpu_hold`=1, state IDLE.
- Any `rst` assertion mid-frame returns every output to its reset value immediately and discards any partially assembled word.
- Write latency: `imem_we` is high in the cycle after the 4th-byte transfer, for exactly one cycle. Address and data are registered and valid in that same cycle.
- Back-to-back bytes at one per cycle are supported. With 4 consecutive transfers per word, writes occur every 4th cycle with no stall.
- Gaps in `rx_valid` only delay progress. No state changes without a transfer.
- `done`/`error` rise in the cycle after the CSUM transfer (or the LEN_HI transfer for overflow). `cpu_hold` falls in that same cycle for DONE.
- `cpu_hold` rises in the cycle after a restarting `load_en`.

## Structure
- Shared package `loader_pkg`:
  - state enum `loader_state_t`;
  - constants `LEN_BYTES`=2 and `WORD_BYTES`=4.
- One natural sub-module: `imem_word_pack`.
  - Function: byte shift register, 2-bit byte counter, word-complete strobe.
  - Everything else (FSM, counters, checksum, outputs) stays in `imem_loader`.

## Test plan
- **Normal load.** Stimulus: `load_en`, then bytes 02 00 93 00 50 00 13 01 A0 00 71.
  - Writes addr0=0x00500093, then addr1=0x00A00113.
  - Then `done`=1, `cpu_hold`=0, `error`=0.
- **Stalled stream.** Stimulus: same frame with random 0–3-cycle `rx_valid` gaps.
  - Identical writes and final state.
  - No extra `imem_we` pulses.
- **Empty frame.** Stimulus: 00 00 00.
  - No `imem_we` pulse.
  - `done`=1, `cpu_hold`=0.
- **Bad checksum.** Stimulus: frame 1 with CSUM 0x70.
  - Both writes still occur.
  - Then `error`=1, `done`=0, `cpu_hold`=1.
  - A following `load_en` plus a good frame ends in `done`=1.
- **Length overflow.** Stimulus: ADDR_W=8, LEN=01 01 (257).
  - `error`=1 in the cycle after LEN_HI.
  - No writes; `rx_ready`=0 thereafter.
- **Reset mid-load.** Stimulus: drop `rst` after the 6th data byte.
  - All outputs take reset values; `cpu_hold`=1.
  - No write for the partial word.
  - A new full frame after reset loads correctly from addr0.
